// File: rtl/vga_timing_if.sv
// Raster timing bundle between the timing generator and the frame-buffer reader / DAC stage.
interface vga_timing_if #(
  parameter int XW = 10,
  parameter int YW = 10,
  parameter int FrameCntW = 8
);
  logic                 pixEn;
  logic [XW-1:0]        x;
  logic [YW-1:0]        y;
  logic                 fetch;
  logic                 de;
  logic                 hSync;
  logic                 vSync;
  logic                 lineStart;
  logic                 frameStart;
  logic [FrameCntW-1:0] frameCount;

  // pixEn is a qualifier, not a handshake: the generator advances on every clk with pixEn=1.
  // There is no back-pressure; the consumer samples x/y/fetch and the delayed controls in the same slot.
  modport master (
    input  pixEn,
    output x, y, fetch, de, hSync, vSync, lineStart, frameStart, frameCount
  );

  modport slave (
    output pixEn,
    input  x, y, fetch, de, hSync, vSync, lineStart, frameStart, frameCount
  );
endinterface

// File: rtl/vga_timing_generator.sv
// Parametrised raster timing generator: x/y counters, frame counter and a Latency-deep
// delayed control path (de, syncs, strobes) aligned to the frame-buffer read latency.
module vga_timing_generator #(
  parameter int HActive   = 640,
  parameter int HFront    = 16,
  parameter int HSyncW    = 96,
  parameter int HBack     = 48,
  parameter int VActive   = 480,
  parameter int VFront    = 10,
  parameter int VSyncW    = 2,
  parameter int VBack     = 33,
  parameter bit HSyncPol  = 1'b0,
  parameter bit VSyncPol  = 1'b0,
  parameter int Latency   = 2,
  parameter int FrameCntW = 8
) (
  input logic         clk,
  input logic         rst,
  vga_timing_if.master bus
);
  localparam int HTotal = HActive + HFront + HSyncW + HBack;
  localparam int VTotal = VActive + VFront + VSyncW + VBack;
  localparam int XW     = $clog2(HTotal);
  localparam int YW     = $clog2(VTotal);

  localparam logic [XW-1:0] XLast   = XW'(HTotal - 1);
  localparam logic [XW-1:0] XActEnd = XW'(HActive);
  localparam logic [XW-1:0] HsStart = XW'(HActive + HFront);
  localparam logic [XW-1:0] HsEnd   = XW'(HActive + HFront + HSyncW);
  localparam logic [YW-1:0] YLast   = YW'(VTotal - 1);
  localparam logic [YW-1:0] YActEnd = YW'(VActive);
  localparam logic [YW-1:0] VsStart = YW'(VActive + VFront);
  localparam logic [YW-1:0] VsEnd   = YW'(VActive + VFront + VSyncW);

  if (HActive < 1 || HFront < 1 || HSyncW < 1 || HBack < 1 ||
      VActive < 1 || VFront < 1 || VSyncW < 1 || VBack < 1 ||
      FrameCntW < 1 || Latency < 0 || Latency > 15) begin : g_bad_params
    $error("vga_timing_generator: zero width parameter or Latency outside 0..15");
  end

  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
    logic ls;
    logic fs;
  } ctl_t;

  logic [XW-1:0]        x_q;
  logic [YW-1:0]        y_q;
  logic [FrameCntW-1:0] fc_q;
  ctl_t                 raw;
  ctl_t                 dly;

  always_ff @(posedge clk) begin
    if (!rst) begin
      x_q  <= '0;
      y_q  <= '0;
      fc_q <= '0;
    end else if (bus.pixEn) begin
      if (x_q == XLast) begin
        x_q <= '0;
        if (y_q == YLast) begin
          y_q  <= '0;
          fc_q <= fc_q + 1'b1;
        end else begin
          y_q <= y_q + 1'b1;
        end
      end else begin
        x_q <= x_q + 1'b1;
      end
    end
  end

  // vs is decoded from y alone, so it changes at the line boundary rather than at an hSync edge.
  always_comb begin
    raw    = '0;
    raw.de = (x_q < XActEnd) && (y_q < YActEnd);
    raw.hs = (x_q >= HsStart) && (x_q < HsEnd);
    raw.vs = (y_q >= VsStart) && (y_q < VsEnd);
    raw.ls = (x_q == '0);
    raw.fs = (x_q == '0) && (y_q == '0);
  end

  if (Latency == 0) begin : g_no_pipe
    assign dly = raw;
  end else begin : g_pipe
    ctl_t pipe [Latency];

    always_ff @(posedge clk) begin
      if (!rst) begin
        for (int i = 0; i < Latency; i++) pipe[i] <= '0;
      end else if (bus.pixEn) begin
        pipe[0] <= raw;
        for (int i = 1; i < Latency; i++) pipe[i] <= pipe[i-1];
      end
    end

    assign dly = pipe[Latency-1];
  end

  assign bus.x          = x_q;
  assign bus.y          = y_q;
  assign bus.frameCount = fc_q;
  assign bus.fetch      = raw.de;
  assign bus.de         = dly.de;
  assign bus.hSync      = dly.hs ^ ~HSyncPol;
  assign bus.vSync      = dly.vs ^ ~VSyncPol;
  assign bus.lineStart  = dly.ls;
  assign bus.frameStart = dly.fs;
endmodule

// File: tb/tb_vga_timing_generator.sv
// Bench for vga_timing_generator: three small-raster instances (Latency 0/2/1, both polarities)
// sharing clk/rst/pixEn, checked against a slot-count reference model.
module tb_vga_timing_generator;
  localparam int HT = 16;
  localparam int VT = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic pix_en = 1'b0;
  int   n_cmp = 0;
  int   n_mis = 0;
  int   n_slot = 0;

  always #5 clk = ~clk;

  vga_timing_if #(.XW(4), .YW(3), .FrameCntW(8)) if_a ();
  vga_timing_if #(.XW(4), .YW(3), .FrameCntW(8)) if_b ();
  vga_timing_if #(.XW(4), .YW(3), .FrameCntW(2)) if_c ();
  assign if_a.pixEn = pix_en;
  assign if_b.pixEn = pix_en;
  assign if_c.pixEn = pix_en;

  vga_timing_generator #(
    .HActive(8), .HFront(2), .HSyncW(3), .HBack(3), .VActive(4), .VFront(1), .VSyncW(2), .VBack(1),
    .HSyncPol(1'b0), .VSyncPol(1'b0), .Latency(0), .FrameCntW(8)
  ) dut_a (.clk(clk), .rst(rst), .bus(if_a));

  vga_timing_generator #(
    .HActive(8), .HFront(2), .HSyncW(3), .HBack(3), .VActive(4), .VFront(1), .VSyncW(2), .VBack(1),
    .HSyncPol(1'b0), .VSyncPol(1'b0), .Latency(2), .FrameCntW(8)
  ) dut_b (.clk(clk), .rst(rst), .bus(if_b));

  vga_timing_generator #(
    .HActive(8), .HFront(2), .HSyncW(3), .HBack(3), .VActive(4), .VFront(1), .VSyncW(2), .VBack(1),
    .HSyncPol(1'b1), .VSyncPol(1'b1), .Latency(1), .FrameCntW(2)
  ) dut_c (.clk(clk), .rst(rst), .bus(if_c));

  // Reference: the whole raster is a function of the number of enabled slots since reset.
  always @(posedge clk) begin
    if (!rst) n_slot <= 0;
    else if (pix_en) n_slot <= n_slot + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_mis++;
      $display("FAIL %s slot=%0d: got %0d expected %0d", name, n_slot, act, exp_v);
    end
  endtask

  task automatic check_inst(input string tag, input int lat, input bit hpol, input bit vpol, input int fcw,
                            input logic [31:0] x, input logic [31:0] y, input logic [31:0] fetch,
                            input logic [31:0] de, input logic [31:0] hs, input logic [31:0] vs,
                            input logic [31:0] ls, input logic [31:0] fs, input logic [31:0] fc);
    int  mx, my, m, dx, dy;
    bit  e_de, e_hs, e_vs, e_ls, e_fs;
    mx = n_slot % HT;
    my = (n_slot / HT) % VT;
    e_de = 0; e_hs = 0; e_vs = 0; e_ls = 0; e_fs = 0;
    if (n_slot >= lat) begin
      m  = n_slot - lat;
      dx = m % HT;
      dy = (m / HT) % VT;
      e_de = (dx < 8) && (dy < 4);
      e_hs = (dx >= 10) && (dx < 13);
      e_vs = (dy >= 5) && (dy < 7);
      e_ls = (dx == 0);
      e_fs = (dx == 0) && (dy == 0);
    end
    chk({tag, ".x"}, x, mx);
    chk({tag, ".y"}, y, my);
    chk({tag, ".fetch"}, fetch, 32'((mx < 8) && (my < 4)));
    chk({tag, ".de"}, de, 32'(e_de));
    chk({tag, ".hSync"}, hs, 32'(hpol ? e_hs : !e_hs));
    chk({tag, ".vSync"}, vs, 32'(vpol ? e_vs : !e_vs));
    chk({tag, ".lineStart"}, ls, 32'(e_ls));
    chk({tag, ".frameStart"}, fs, 32'(e_fs));
    chk({tag, ".frameCount"}, fc, (n_slot / (HT * VT)) % (1 << fcw));
  endtask

  task automatic check_all();
    check_inst("a", 0, 1'b0, 1'b0, 8, if_a.x, if_a.y, if_a.fetch, if_a.de, if_a.hSync, if_a.vSync,
               if_a.lineStart, if_a.frameStart, if_a.frameCount);
    check_inst("b", 2, 1'b0, 1'b0, 8, if_b.x, if_b.y, if_b.fetch, if_b.de, if_b.hSync, if_b.vSync,
               if_b.lineStart, if_b.frameStart, if_b.frameCount);
    check_inst("c", 1, 1'b1, 1'b1, 2, if_c.x, if_c.y, if_c.fetch, if_c.de, if_c.hSync, if_c.vSync,
               if_c.lineStart, if_c.frameStart, if_c.frameCount);
  endtask

  // Inputs change on the falling edge; outputs are read on the following falling edge.
  task automatic apply(input bit r, input bit pe);
    rst    = r;
    pix_en = pe;
    @(negedge clk);
  endtask

  typedef struct {
    bit r;
    bit pe;
    int x;
    int y;
    bit de;
    bit hs;
    bit fs;
  } vec_t;

  vec_t vt [8];

  initial begin
    vt[0] = '{r:0, pe:1, x:0, y:0, de:0, hs:1, fs:0};
    vt[1] = '{r:0, pe:1, x:0, y:0, de:0, hs:1, fs:0};
    vt[2] = '{r:0, pe:1, x:0, y:0, de:0, hs:1, fs:0};
    vt[3] = '{r:1, pe:1, x:1, y:0, de:0, hs:1, fs:0};
    vt[4] = '{r:1, pe:1, x:2, y:0, de:1, hs:1, fs:1};
    vt[5] = '{r:1, pe:0, x:2, y:0, de:1, hs:1, fs:1};
    vt[6] = '{r:1, pe:0, x:2, y:0, de:1, hs:1, fs:1};
    vt[7] = '{r:1, pe:1, x:3, y:0, de:1, hs:1, fs:0};

    @(negedge clk);

    // Reset and first slots of the Latency=2 instance, including a stalled strobe.
    for (int i = 0; i < 8; i++) begin
      apply(vt[i].r, vt[i].pe);
      chk("tbl.x", if_b.x, vt[i].x);
      chk("tbl.y", if_b.y, vt[i].y);
      chk("tbl.de", if_b.de, vt[i].de);
      chk("tbl.hSync", if_b.hSync, vt[i].hs);
      chk("tbl.frameStart", if_b.frameStart, vt[i].fs);
      if (i < 3) begin
        chk("tbl.rst_vSync", if_b.vSync, 1);
        chk("tbl.rst_frameCount", if_b.frameCount, 0);
        chk("tbl.rst_c_hSync", if_c.hSync, 0);
        chk("tbl.rst_c_vSync", if_c.vSync, 0);
      end
    end

    // Randomized pixEn gaps and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      apply($urandom_range(0, 399) != 0, $urandom_range(0, 3) != 0);
      check_all();
    end

    // Reset mid-frame at x=5, y=2.
    apply(1'b0, 1'b1);
    for (int i = 0; i < 37; i++) apply(1'b1, 1'b1);
    chk("mid.x_before", if_b.x, 5);
    chk("mid.y_before", if_b.y, 2);
    apply(1'b0, 1'b1);
    chk("mid.x", if_b.x, 0);
    chk("mid.y", if_b.y, 0);
    chk("mid.frameCount", if_b.frameCount, 0);
    chk("mid.de0", if_b.de, 0);
    apply(1'b1, 1'b1);
    chk("mid.de1", if_b.de, 0);
    apply(1'b1, 1'b1);
    chk("mid.de2", if_b.de, 1);

    // Free run through four frames: frame count at 128 enabled slots, 2-bit wrap 3->0.
    apply(1'b0, 1'b1);
    for (int i = 1; i <= 512; i++) begin
      apply(1'b1, (i % 5) != 0 || i == 512);
      if ((i % 5) == 0 && i != 512) apply(1'b1, 1'b1);
      check_all();
      if (n_slot == 128) chk("run.a_frameCount_128", if_a.frameCount, 1);
      if (n_slot == 511) chk("run.c_frameCount_511", if_c.frameCount, 3);
      if (n_slot == 512) chk("run.c_frameCount_wrap", if_c.frameCount, 0);
    end
    chk("run.a_frameCount_end", if_a.frameCount, n_slot / 128);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
